mem_bus_if: RTL and testbench
=============================

Name: mem_bus_if

Overview:
- Memory-stage bus master at the consuming end of the EX/MEM pipeline register.
- Takes the latched load/store operation (aluop, effective address, store data) and runs it over a single-outstanding req/ack data bus.
- Holds the pipeline via stallreq until the access completes.
- Produces the write-back triple (register address, write enable, data), with loaded data aligned and extended.

Parameters:
- BUS_AW, 32: data bus address width. Always equals the full 32-bit mem_mem_addr width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high (1 = reset)
- stall  in  6  pipeline stall vector; bit 4 = MEM/WB stage held
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  destination write enable
- mem_wdata  in  32  ALU result for non-memory ops
- mem_aluop  in  8  operation code
- mem_mem_addr  in  32  effective byte address
- mem_reg2  in  32  store data
- bus_req  out  1  access request
- bus_we  out  1  1 = store
- bus_addr  out  32  word address, low 2 bits always 0
- bus_sel  out  4  byte-lane enables; bit 3 = bits 31:24
- bus_wdata  out  32  replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion pulse
- wb_wd  out  5  write-back register address
- wb_wreg  out  1  write-back enable
- wb_wdata  out  32  write-back data
- stallreq  out  1  request to hold the pipeline

Behaviour:
Opcodes:
- Loads: LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5.
- Stores: SB 8'hE8, SH 8'hE9, SW 8'hEB.
- Any other value is a non-memory op.

Byte-lane mapping (big-endian):
- Byte ops: addr[1:0] = 00/01/10/11 -> sel 1000/0100/0010/0001.
- Halfword ops: addr[1] = 0 -> sel 1100; addr[1] = 1 -> sel 0011.
- Word ops: sel 1111.
- Store data: SB drives reg2[7:0] on all four lanes; SH drives {reg2[15:0], reg2[15:0]}; SW drives reg2.

FSM states: IDLE, BUSY, DONE.
- IDLE, memory op present: next state BUSY. On the same edge, register bus_req=1 and register bus_we, bus_addr, bus_sel, bus_wdata.
- BUSY: bus_req and the registered bus signals are held constant until bus_ack. On ack: bus_req<=0, capture the extended load data into a 32-bit load buffer, next state DONE.
- DONE: stallreq=0. Return to IDLE on the first edge with stall[4]=0. Remain in DONE while stall[4]=1.

Handshake rules:
- bus_ack while in IDLE or DONE is ignored.
- Only one access is outstanding at a time.

stallreq:
- Combinational: 1 when a memory op is present and state != DONE.
- Minimum stall is 2 cycles: request edge plus ack cycle.

Write-back outputs (combinational, driven in every state):
- wb_wd = mem_wd, wb_wreg = mem_wreg.
- wb_wdata = mem_wdata for non-memory ops and stores; = load buffer for loads.

Load extension:
- LB/LH sign-extend from bit 7/15 of the selected lane.
- LBU/LHU zero-extend.

Reset and the Stop/NoStop handling:
- rst=1: bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, load buffer=0, state=IDLE.
- Reset in BUSY abandons the access: bus_req drops on that edge, and any later ack is ignored.
- A non-memory op never leaves IDLE and never asserts bus_req.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: adds output misalign (1 bit). Misalignment is: halfword ops with addr[0]=1; word ops with addr[1:0]!=0.
  - A misaligned op in IDLE stays in IDLE and issues no bus_req.
  - It drives misalign=1 combinationally, forces wb_wreg=0 and stallreq=0.
- Not defined: no misalign port. Misaligned low bits are ignored (halfword uses addr[1], word uses sel 1111) and the access proceeds normally.

Test Plan:
- LW addr 0x0000_1004, ack on 2nd BUSY cycle, rdata 0xDEADBEEF -> bus_addr 0x1004, sel 1111, we=0; stallreq high 3 cycles; wb_wdata 0xDEADBEEF in DONE.
- LB addr 0x1001, rdata 0x1280_3456 -> sel 0100, wb_wdata 0xFFFFFF80. Same access as LBU -> 0x0000_0080.
- SH addr 0x2002, reg2 0x0000_ABCD, immediate ack -> we=1, sel 0011, bus_wdata 0xABCD_ABCD, stallreq exactly 2 cycles.
- Non-memory op aluop 8'h25, mem_wdata 0x55 -> bus_req never asserted, stallreq=0, wb_wdata 0x55 same cycle.
- rst pulsed while BUSY, then ack arrives -> bus_req=0 the next cycle, state IDLE, ack ignored, wb load buffer 0.
- DONE with stall[4]=1 for 3 cycles -> wb_wdata stable, no new bus_req until stall[4]=0. With MEM_ALIGN_CHECK_EN: LW addr 0x1002 -> misalign=1, no bus_req.

Source files
------------

// File: rtl/mem_bus_if.sv
// Memory-stage bus master: turns the EX/MEM load/store into one req/ack bus access and
// builds the write-back triple. Optional `MEM_ALIGN_CHECK_EN adds misaligned-access rejection.
module mem_bus_if #(
    parameter int BUS_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [31:0]       mem_mem_addr,
    input  logic [31:0]       mem_reg2,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              stallreq
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [BUS_AW-1:0] r_bus_addr;
    logic [3:0]        r_bus_sel;
    logic [31:0]       r_bus_wdata;
    logic [31:0]       r_load_buf;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_go;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic        w_unused;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        case (mem_aluop)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            OP_LW:         begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            OP_SB:         begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            OP_SH:         begin w_is_store = 1'b1; w_is_half = 1'b1; end
            OP_SW:         begin w_is_store = 1'b1; w_is_word = 1'b1; end
            default:       ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half & mem_mem_addr[0]) |
                        (w_is_word & (mem_mem_addr[1:0] != 2'b00));
    assign misalign   = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go = (w_is_load | w_is_store) & ~w_misalign;

    // Big-endian lanes: byte offset 0 lives on bits 31:24.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_reg2;
        if (w_is_byte) begin
            w_sel   = 4'b1000 >> mem_mem_addr[1:0];
            w_wdata = {4{mem_reg2[7:0]}};
        end else if (w_is_half) begin
            w_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            w_wdata = {2{mem_reg2[15:0]}};
        end
    end

    always_comb begin
        case (mem_mem_addr[1:0])
            2'b00:   w_byte = bus_rdata[31:24];
            2'b01:   w_byte = bus_rdata[23:16];
            2'b10:   w_byte = bus_rdata[15:8];
            default: w_byte = bus_rdata[7:0];
        endcase
        w_half = mem_mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (mem_aluop)
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h000000, w_byte};
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_load_buf  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state     <= S_BUSY;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {mem_mem_addr[BUS_AW-1:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_wdata;
                    end
                end
                S_BUSY: begin
                    if (bus_ack) begin
                        r_state    <= S_DONE;
                        r_bus_req  <= 1'b0;
                        r_load_buf <= w_load_ext;
                    end
                end
                S_DONE: begin
                    // Hold the result until the MEM/WB register actually takes it.
                    if (!stall[4]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_sel   = r_bus_sel;
    assign bus_wdata = r_bus_wdata;

    assign stallreq = w_go & (r_state != S_DONE);
    assign wb_wd    = mem_wd;
    assign wb_wreg  = mem_wreg & ~w_misalign;
    assign wb_wdata = w_is_load ? r_load_buf : mem_wdata;

    assign w_unused = &{1'b0, stall[5], stall[3:0]};

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: a driver pushes expected bus/write-back results,
// a bus slave acks with scripted delays, and negedge monitors pop and compare.
module tb_mem_bus_if;

    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
    localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall;
    logic [4:0]  mem_wd = 5'd0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = 32'h0;
    logic [7:0]  mem_aluop = 8'h00;
    logic [31:0] mem_mem_addr = 32'h0;
    logic [31:0] mem_reg2 = 32'h0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    logic hold = 1'b0;
    assign stall = {1'b0, stallreq | hold, 4'b0000};

    mem_bus_if #(.BUS_AW(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic [4:0] wd; logic wreg; logic [31:0] data; int stalls; } wb_exp_t;
    typedef struct { int dly; logic [31:0] data; } rd_t;

    bus_exp_t q_bus[$];
    wb_exp_t  q_wb[$];
    rd_t      q_rd[$];

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit slave_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_load(input logic [7:0] op);
        return op == LB || op == LH || op == LW || op == LBU || op == LHU;
    endfunction
    function automatic bit is_store(input logic [7:0] op);
        return op == SB || op == SH || op == SW;
    endfunction
    function automatic int op_size(input logic [7:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction
    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] a);
        int sz = op_size(op);
        if (sz == 1) return 4'b1000 >> (a % 4);
        if (sz == 2) return 4'b1100 >> (2 * ((a / 2) % 2));
        return 4'b1111;
    endfunction
    function automatic logic [31:0] exp_bwdata(input logic [7:0] op, input logic [31:0] r);
        int sz = op_size(op);
        if (sz == 1) return (r & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction
    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int sz = op_size(op);
        if (sz == 1) begin
            v = (rd >> (8 * (3 - (a % 4)))) & 32'hFF;
            if (op == LB && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (rd >> (16 * (1 - ((a / 2) % 2)))) & 32'hFFFF;
            if (op == LH && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] rd, input int dly, input int hold_k);
        bus_exp_t be;
        wb_exp_t  we;
        rd_t      rr;
        int       t;
        mem_aluop = op; mem_mem_addr = a; mem_reg2 = r2;
        mem_wdata = wdat; mem_wd = wd; mem_wreg = wreg;
        hold = (hold_k > 0);
        we.wd = wd; we.wreg = wreg;
        we.data = is_load(op) ? exp_load(op, a, rd) : wdat;
        we.stalls = (is_load(op) || is_store(op)) ? dly + 2 : 0;
        q_wb.push_back(we);
        if (is_load(op) || is_store(op)) begin
            be.we = is_store(op); be.addr = a & 32'hFFFF_FFFC;
            be.sel = exp_sel(op, a); be.wdata = exp_bwdata(op, r2);
            q_bus.push_back(be);
            rr.dly = dly; rr.data = rd;
            q_rd.push_back(rr);
        end
        #1;
        t = 0;
        while (stallreq) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                n_err++;
                $display("FAIL access_timeout: stallreq still 1 after %0d cycles (op 0x%02h)", t, op);
                finish_run();
            end
        end
        repeat (hold_k) begin
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- bus slave ----------------
    initial begin
        rd_t cur;
        bit  started = 1'b0;
        cur.dly = 0; cur.data = 32'h0;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                if (bus_ack) begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end else if (bus_req) begin
                    if (!started) begin
                        started = 1'b1;
                        if (q_rd.size() == 0) begin
                            n_err++;
                            $display("FAIL slave_req: got unexpected request, required none");
                            cur.dly = 0; cur.data = 32'h0;
                        end else begin
                            cur = q_rd.pop_front();
                        end
                    end
                    if (cur.dly == 0) begin
                        bus_ack   = 1'b1;
                        bus_rdata = cur.data;
                        started   = 1'b0;
                    end else begin
                        cur.dly--;
                    end
                end else begin
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    initial begin
        bus_exp_t cur;
        logic     req_prev = 1'b0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.sel = 4'h0; cur.wdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mon_en && bus_req) begin
                if (!req_prev) begin
                    n_cmp++;
                    if (q_bus.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_req_spurious: got bus_req=1 addr 0x%08h, required 0", bus_addr);
                    end else begin
                        cur = q_bus.pop_front();
                    end
                end
                chk("bus_we", {31'h0, bus_we}, {31'h0, cur.we});
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_sel", {28'h0, bus_sel}, {28'h0, cur.sel});
                chk("bus_wdata", bus_wdata, cur.wdata);
            end
            req_prev = bus_req;
        end
    end

    // ---------------- write-back monitor ----------------
    initial begin
        int cnt = 0;
        bit first = 1'b1;
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && q_wb.size() != 0) begin
                if (stallreq) begin
                    cnt++;
                end else begin
                    e = q_wb[0];
                    if (first) begin
                        chk("stall_cycles", cnt, e.stalls);
                        first = 1'b0;
                    end
                    chk("wb_wd", {27'h0, wb_wd}, {27'h0, e.wd});
                    chk("wb_wreg", {31'h0, wb_wreg}, {31'h0, e.wreg});
                    chk("wb_wdata", wb_wdata, e.data);
                    if (!stall[4]) begin
                        void'(q_wb.pop_front());
                        first = 1'b1;
                        cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  ops [8];
        logic [7:0]  op;
        logic [31:0] a;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

        mem_aluop = LW; mem_mem_addr = 32'h0000_1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_sel", {28'h0, bus_sel}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_load_buf", wb_wdata, 32'h0);
        rst = 1'b0;
        mem_aluop = 8'h25;
        mon_en = 1'b1; slave_en = 1'b1;
        @(posedge clk); #1;

        issue(LW,  32'h0000_1004, 32'h0,         32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF, 1, 0);
        issue(LB,  32'h0000_1001, 32'h0,         32'h0, 5'd4, 1'b1, 32'h1280_3456, 0, 0);
        issue(LBU, 32'h0000_1001, 32'h0,         32'h0, 5'd5, 1'b1, 32'h1280_3456, 0, 0);
        issue(SH,  32'h0000_2002, 32'h0000_ABCD, 32'h7, 5'd0, 1'b0, 32'h0,         0, 0);
        issue(8'h25, 32'h0,       32'h0,         32'h55, 5'd6, 1'b1, 32'h0,        0, 0);
        issue(LH,  32'h0000_3000, 32'h0,         32'h0, 5'd7, 1'b1, 32'h8001_7FFF, 2, 3);
        issue(LHU, 32'h0000_3002, 32'h0,         32'h0, 5'd8, 1'b1, 32'h8001_F00F, 0, 0);
        issue(SB,  32'h0000_4003, 32'h1234_56A5, 32'h9, 5'd9, 1'b0, 32'h0,         3, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 8'($urandom); while (is_load(op) || is_store(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            a = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            if (op_size(op) == 2) a[0] = 1'b0;
            if (op_size(op) == 4) a[1:0] = 2'b00;
`endif
            issue(op, a, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 2));
        end

        chk("q_wb_drained", q_wb.size(), 32'h0);
        chk("q_bus_drained", q_bus.size(), 32'h0);
        chk("q_rd_drained", q_rd.size(), 32'h0);

        // Reset while BUSY abandons the access; a stray ack in IDLE must not load data.
        mon_en = 1'b0; slave_en = 1'b0; bus_ack = 1'b0;
        mem_aluop = LW; mem_mem_addr = 32'h0000_3000; mem_wreg = 1'b1; mem_wd = 5'd1;
        @(posedge clk); #1;
        chk("rstbusy_req_before", {31'h0, bus_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstbusy_req_after", {31'h0, bus_req}, 32'h0);
        chk("rstbusy_loadbuf", wb_wdata, 32'h0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_ignored", wb_wdata, 32'h0);
        chk("reissue_req", {31'h0, bus_req}, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("reissue_data", wb_wdata, 32'h1122_3344);
        chk("reissue_stallreq", {31'h0, stallreq}, 32'h0);
        mem_aluop = 8'h25;
        @(posedge clk); #1;
        chk("final_idle_req", {31'h0, bus_req}, 32'h0);

        finish_run();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
